// File: rtl/pic_pkg.sv
// Shared constants and command decode for the pic8259_lite interrupt controller.
package pic_pkg;

   localparam logic [14:0] PIC_W0_OFS   = 15'd0;
   localparam logic [14:0] PIC_W1_OFS   = 15'd1;
   localparam logic [7:0]  EOI_NONSPEC  = 8'h20;
   localparam logic [2:0]  EOI_SPEC     = 3'b011;
   localparam logic [7:0]  IMR_RESET    = 8'hFF;
   localparam logic [2:0]  SPURIOUS_IDX = 3'd7;

   typedef enum logic [1:0] {
      REG_NONE,
      REG_W0,
      REG_W1
   } reg_sel_e;

   typedef enum logic [1:0] {
      CMD_NONE,
      CMD_EOI_NONSPEC,
      CMD_EOI_SPEC
   } cmd_e;

   // Specific EOI is exactly 8'h60..8'h67; everything else that is not 8'h20 is ignored.
   function automatic cmd_e decode_cmd(input logic [7:0] i_byte);
      cmd_e v_cmd;
      v_cmd = CMD_NONE;
      if (i_byte == EOI_NONSPEC)
         v_cmd = CMD_EOI_NONSPEC;
      else if (i_byte[7:5] == EOI_SPEC && i_byte[4:3] == 2'b00)
         v_cmd = CMD_EOI_SPEC;
      return v_cmd;
   endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// 8-bit priority encoder: the lowest set index wins, o_valid flags any set bit.
module pic_prio_enc (
   input  logic [7:0] i_req,
   output logic [2:0] o_idx,
   output logic       o_valid
);

   always_comb begin
      // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
      o_idx   = 3'd0;
      o_valid = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx   = 3'(i);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pic8259_lite.sv
// Edge-triggered 8-input interrupt controller with fixed, fully nested priority
// and a two-word I/O register interface on the core's OR-combined return bus.
module pic8259_lite
   import pic_pkg::*;
#(
   parameter logic [15:0] BASE_PORT = 16'h0020,
   parameter logic [7:0]  VEC_RESET = 8'h08
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        io_access,
   input  logic [15:1] io_addr,
   input  logic        io_wr_en,
   input  logic [1:0]  io_bytesel,
   input  logic [15:0] io_wdata,
   output logic [15:0] io_rdata,
   output logic        io_ack,
   input  logic [7:0]  irq_in,
   output logic        intr,
   input  logic        inta,
   output logic [7:0]  irq
);

   logic [7:0]  r_sync1, r_sync2, r_sync3;
   logic [7:0]  r_irr, r_isr, r_imr;
   logic [4:0]  r_base;
   logic        r_inta_q;
   logic        r_intr;
   logic [7:0]  r_irq;
   logic        r_ack;
   logic [15:0] r_rdata;

   logic [7:0]  w_edge, w_pend, w_eoi_clr, w_ack_set, w_isr_next, w_irr_next;
   logic [2:0]  w_pend_idx, w_isr_idx;
   logic        w_pend_v, w_isr_v, w_inta_edge;
   logic [15:0] w_rdata;
   reg_sel_e    w_sel;
   cmd_e        w_cmd;
   logic        w_unused_wdata;

   assign w_edge         = r_sync2 & ~r_sync3;
   assign w_pend         = r_irr & ~r_imr;
   assign w_inta_edge    = inta & ~r_inta_q;
   assign w_cmd          = decode_cmd(io_wdata[7:0]);
   assign w_unused_wdata = ^io_wdata[10:8];

   pic_prio_enc u_pend_enc (.i_req(w_pend), .o_idx(w_pend_idx), .o_valid(w_pend_v));
   pic_prio_enc u_isr_enc  (.i_req(r_isr),  .o_idx(w_isr_idx),  .o_valid(w_isr_v));

   // The core holds io_access through the ack cycle, so that cycle is not a new access.
   always_comb begin
      w_sel = REG_NONE;
      if (io_access && !r_ack) begin
         if (io_addr == BASE_PORT[15:1] + PIC_W0_OFS)
            w_sel = REG_W0;
         else if (io_addr == BASE_PORT[15:1] + PIC_W1_OFS)
            w_sel = REG_W1;
      end
   end

   always_comb begin
      w_rdata = 16'h0000;
      case (w_sel)
         REG_W0:  w_rdata = {r_isr, r_irr};
         REG_W1:  w_rdata = {r_base, 3'b000, r_imr};
         default: w_rdata = 16'h0000;
      endcase
   end

   // EOI clears first, then the acknowledge sets, so both can land on one edge.
   always_comb begin
      w_eoi_clr = 8'h00;
      w_ack_set = 8'h00;
      if (w_sel == REG_W0 && io_wr_en && io_bytesel[0]) begin
         case (w_cmd)
            CMD_EOI_NONSPEC: if (w_isr_v) w_eoi_clr[w_isr_idx] = 1'b1;
            CMD_EOI_SPEC:    w_eoi_clr[io_wdata[2:0]] = 1'b1;
            default:         w_eoi_clr = 8'h00;
         endcase
      end
      if (w_inta_edge && w_pend_v)
         w_ack_set[w_pend_idx] = 1'b1;
   end

   assign w_isr_next = (r_isr & ~w_eoi_clr) | w_ack_set;
   assign w_irr_next = (r_irr & ~w_ack_set) | w_edge;

   // NOTE: every register here uses <= so all of them see pre-edge values of each other.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= 8'h00;
         r_sync2  <= 8'h00;
         r_sync3  <= 8'h00;
         r_irr    <= 8'h00;
         r_isr    <= 8'h00;
         r_imr    <= IMR_RESET;
         r_base   <= VEC_RESET[7:3];
         r_inta_q <= 1'b1;  // an inta already high at reset must fall before it counts
         r_intr   <= 1'b0;
         r_irq    <= 8'h00;
         r_ack    <= 1'b0;
         r_rdata  <= 16'h0000;
      end else begin
         r_sync1  <= irq_in;
         r_sync2  <= r_sync1;
         r_sync3  <= r_sync2;
         r_inta_q <= inta;
         r_irr    <= w_irr_next;
         r_isr    <= w_isr_next;
         if (w_sel == REG_W1 && io_wr_en) begin
            if (io_bytesel[0]) r_imr  <= io_wdata[7:0];
            if (io_bytesel[1]) r_base <= io_wdata[15:11];
         end
         if (w_inta_edge)
            r_irq <= w_pend_v ? {r_base, w_pend_idx} : {r_base, SPURIOUS_IDX};
         r_intr  <= w_pend_v && (!w_isr_v || (w_pend_idx < w_isr_idx));
         r_ack   <= (w_sel != REG_NONE);
         r_rdata <= w_rdata;
      end
   end

   assign io_ack   = r_ack;
   assign io_rdata = r_rdata;
   assign intr     = r_intr;
   assign irq      = r_irq;

endmodule

// File: tb/tb_pic8259_lite.sv
// Self-checking bench for pic8259_lite: register vectors from a table, then
// hand-written interrupt sequences; I/O responses are checked through a scoreboard.
module tb_pic8259_lite;

   logic        clk = 1'b0;
   logic        reset;
   logic        io_access, io_wr_en, inta;
   logic [15:1] io_addr;
   logic [1:0]  io_bytesel;
   logic [15:0] io_wdata, io_rdata;
   logic        io_ack, intr;
   logic [7:0]  irq_in, irq;

   always #5 clk = ~clk;

   pic8259_lite dut (
      .clk(clk), .reset(reset), .io_access(io_access), .io_addr(io_addr),
      .io_wr_en(io_wr_en), .io_bytesel(io_bytesel), .io_wdata(io_wdata),
      .io_rdata(io_rdata), .io_ack(io_ack), .irq_in(irq_in), .intr(intr),
      .inta(inta), .irq(irq)
   );

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [15:0] addr;
      logic        wr;
      logic [1:0]  bsel;
      logic [15:0] wdata;
      logic        exp_ack;
      logic        chk_rd;
      logic [15:0] exp_rd;
   } vec_t;

   typedef struct {
      string       name;
      logic        ack;
      logic        chk_rd;
      logic [15:0] rd;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[14];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic io_op(input string name, input logic [15:0] addr, input logic wr,
                        input logic [1:0] bsel, input logic [15:0] wdata,
                        input logic exp_ack, input logic chk_rd, input logic [15:0] exp_rd);
      exp_t e;
      @(negedge clk);
      io_access  = 1'b1;
      io_addr    = addr[15:1];
      io_wr_en   = wr;
      io_bytesel = bsel;
      io_wdata   = wdata;
      e.name = name; e.ack = exp_ack; e.chk_rd = chk_rd; e.rd = exp_rd;
      sb.push_back(e);
      @(negedge clk);
      io_access = 1'b0;
      io_wr_en  = 1'b0;
      e = sb.pop_front();
      check({e.name, "_ack"}, 16'(io_ack), 16'(e.ack));
      if (e.chk_rd) check({e.name, "_rdata"}, io_rdata, e.rd);
   endtask

   task automatic rd(input string name, input logic [15:0] addr, input logic [15:0] exp);
      io_op(name, addr, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b1, exp);
   endtask

   task automatic wr(input string name, input logic [15:0] addr, input logic [1:0] bsel,
                     input logic [15:0] data);
      io_op(name, addr, 1'b1, bsel, data, 1'b1, 1'b0, 16'h0000);
   endtask

   task automatic pulse_irq(input int n);
      @(negedge clk);
      irq_in[n] = 1'b1;
      repeat (2) @(negedge clk);
      irq_in[n] = 1'b0;
   endtask

   task automatic wait_intr(input string name, input logic exp, input int budget);
      int k = 0;
      while (intr !== exp && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, 16'(intr), 16'(exp));
   endtask

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_inta(input string name, input logic [7:0] exp);
      @(negedge clk);
      inta = 1'b1;
      @(negedge clk);
      check(name, 16'(irq), 16'(exp));
      inta = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //             addr      wr    bsel   wdata     ack   chk   rdata
      vecs[0]  = '{16'h0022, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b1, 16'h08FF};
      vecs[1]  = '{16'h0020, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b1, 16'h0000};
      vecs[2]  = '{16'h0024, 1'b0, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h0000};
      vecs[3]  = '{16'h0023, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b1, 16'h08FF};
      vecs[4]  = '{16'h0022, 1'b1, 2'b01, 16'h1234, 1'b1, 1'b0, 16'h0000};
      vecs[5]  = '{16'h0022, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b1, 16'h0834};
      vecs[6]  = '{16'h0022, 1'b1, 2'b10, 16'h7A00, 1'b1, 1'b0, 16'h0000};
      vecs[7]  = '{16'h0022, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b1, 16'h7834};
      vecs[8]  = '{16'h0020, 1'b1, 2'b10, 16'hFF00, 1'b1, 1'b0, 16'h0000};
      vecs[9]  = '{16'h0020, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b1, 16'h0000};
      vecs[10] = '{16'h0022, 1'b1, 2'b11, 16'h08FE, 1'b1, 1'b0, 16'h0000};
      vecs[11] = '{16'h0022, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b1, 16'h08FE};
      vecs[12] = '{16'h0024, 1'b1, 2'b11, 16'h0000, 1'b0, 1'b1, 16'h0000};
      vecs[13] = '{16'h0022, 1'b0, 2'b11, 16'h0000, 1'b1, 1'b1, 16'h08FE};

      reset = 1'b1; io_access = 1'b0; io_wr_en = 1'b0; inta = 1'b0;
      io_addr = '0; io_bytesel = 2'b00; io_wdata = 16'h0000; irq_in = 8'h00;
      settle(3);
      reset = 1'b0;
      check("rst_intr",  16'(intr),   16'h0000);
      check("rst_irq",   16'(irq),    16'h0000);
      check("rst_ack",   16'(io_ack), 16'h0000);
      check("rst_rdata", io_rdata,    16'h0000);

      foreach (vecs[i])
         io_op($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].bsel,
               vecs[i].wdata, vecs[i].exp_ack, vecs[i].chk_rd, vecs[i].exp_rd);

      // Single request on the highest-priority line.
      pulse_irq(0);
      wait_intr("single_intr_rise", 1'b1, 6);
      rd("single_irr", 16'h0020, 16'h0001);
      do_inta("single_vec", 8'h08);
      wait_intr("single_intr_fall", 1'b0, 4);
      rd("single_isr", 16'h0020, 16'h0100);
      wr("single_eoi", 16'h0020, 2'b01, 16'h0020);
      rd("single_isr_clr", 16'h0020, 16'h0000);

      // Nesting: a lower-priority request waits, a higher one preempts.
      wr("nest_imr", 16'h0022, 2'b11, 16'h0800);
      pulse_irq(3);
      wait_intr("nest_intr3", 1'b1, 6);
      do_inta("nest_vec3", 8'h0B);
      pulse_irq(5);
      settle(6);
      check("nest_intr5_blocked", 16'(intr), 16'h0000);
      pulse_irq(1);
      wait_intr("nest_intr1", 1'b1, 6);
      do_inta("nest_vec1", 8'h09);
      rd("nest_regs", 16'h0020, 16'h0A20);
      wr("nest_spec_eoi", 16'h0020, 2'b01, 16'h0061);
      rd("nest_after_spec", 16'h0020, 16'h0820);
      wr("nest_nonspec_eoi", 16'h0020, 2'b01, 16'h0020);
      wait_intr("nest_intr5_released", 1'b1, 4);
      do_inta("nest_vec5", 8'h0D);
      wr("nest_eoi5", 16'h0020, 2'b01, 16'h0020);
      rd("nest_clean", 16'h0020, 16'h0000);

      // Masking and vector base.
      wr("mask_imr", 16'h0022, 2'b01, 16'h00FB);
      wr("mask_base", 16'h0022, 2'b10, 16'h7000);
      rd("mask_w1", 16'h0022, 16'h70FB);
      pulse_irq(2);
      wait_intr("mask_intr2", 1'b1, 6);
      do_inta("mask_vec2", 8'h72);
      wr("mask_eoi", 16'h0020, 2'b01, 16'h0020);
      pulse_irq(4);
      settle(6);
      check("mask_intr4_blocked", 16'(intr), 16'h0000);
      rd("mask_irr4", 16'h0020, 16'h0010);

      // Spurious acknowledge with nothing pending.
      do_inta("spurious_vec", 8'h77);
      rd("spurious_regs", 16'h0020, 16'h0010);

      // New edge on bit 0 detected on the same edge that acknowledges bit 0.
      wr("coll_imr", 16'h0022, 2'b01, 16'h00FE);
      pulse_irq(0);
      wait_intr("coll_intr", 1'b1, 6);
      settle(4);
      @(negedge clk);
      irq_in[0] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      inta = 1'b1;
      @(negedge clk);
      check("coll_vec", 16'(irq), 16'h0070);
      inta = 1'b0;
      irq_in[0] = 1'b0;
      rd("coll_regs", 16'h0020, 16'h0111);
      wait_intr("coll_intr_low", 1'b0, 4);

      // Reset with an access pending and inta held high.
      @(negedge clk);
      reset = 1'b1;
      inta = 1'b1;
      io_access = 1'b1;
      io_addr = 15'h0011;
      io_wr_en = 1'b0;
      @(negedge clk);
      check("rst_pending_ack", 16'(io_ack), 16'h0000);
      io_access = 1'b0;
      settle(2);
      reset = 1'b0;
      settle(3);
      check("rst_inta_no_edge", 16'(irq), 16'h0000);
      inta = 1'b0;
      rd("rst_w1", 16'h0022, 16'h08FF);
      do_inta("rst_spurious_vec", 8'h0F);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pic8259_lite.md
# pic8259_lite

Edge-triggered 8-input interrupt controller that sits on the core's I/O data path as a responder and drives the core's `intr`/`inta`/`irq` interrupt interface. It is the other end of the interrupt handshake: it collects peripheral requests, arbitrates by fixed priority with full nesting, raises `intr`, and supplies the vector byte when the core acknowledges. Its read data and ack join the top-level OR-combined I/O return bus alongside the existing port logic.

## Interface
- `BASE_PORT`, 16'h0020: I/O byte address of register word 0. Word 1 is at `BASE_PORT+2`. Bit 0 is ignored.
- `VEC_RESET`, 8'h08: reset value of the vector base register.

- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `io_access`  in  1  I/O cycle request: `d_io & data_m_access`, held until ack
- `io_addr`  in  15  word address [15:1], taken from `data_m_addr[15:1]`
- `io_wr_en`  in  1  write strobe
- `io_bytesel`  in  2  byte lanes; [0] is low, [1] is high
- `io_wdata`  in  16  write data
- `io_rdata`  out  16  read data; zero whenever `io_ack` is 0
- `io_ack`  out  1  one-cycle acknowledge
- `irq_in`  in  8  asynchronous request lines, rising-edge sensitive; 0 has the highest priority
- `intr`  out  1  interrupt request to the core
- `inta`  in  1  acknowledge from the core, level
- `irq`  out  8  vector number to the core

## Operation
- **Input sampling.** Each `irq_in` bit passes through a 2-flop synchronizer, then a rising-edge detector.
  - A detected edge sets the matching IRR bit.
- **Register map.** Word 0 = `BASE_PORT`, word 1 = `BASE_PORT+2`. Only lanes enabled by `io_bytesel` are written.
  - Word 0, low byte, write: command.
    - 8'h20: non-specific EOI, clears the highest-priority set ISR bit.
    - 8'h60|n: specific EOI, clears ISR[n].
    - Any other value: ignored.
  - Word 0, low byte, read: IRR.
  - Word 0, high byte: read ISR; writes ignored.
  - Word 1, low byte: IMR, read/write.
  - Word 1, high byte: vector base. Bits [7:3] are writable; bits [2:0] read 0.
- **Decode.** A request whose address matches neither word gets no ack and zero data. Another responder owns it.
- **Arbitration.**
  - `pend = IRR & ~IMR`.
  - `intr = 1` when the lowest-index bit of `pend` has higher priority than the lowest-index set ISR bit, or when ISR is 0.
- **Acknowledge.** On an `inta` rising edge (`inta & ~inta_q`), take `pend`:
  - If `pend` is non-zero, let n be its highest-priority bit. Set ISR[n], clear IRR[n], and set `irq <= base[7:3]·n`.
  - If `pend` is zero (spurious), set `irq <= base[7:3]·3'b111` and leave ISR and IRR unchanged.
  - `irq` holds its value until the next `inta` edge.

## Timing
- **Reset values:** IRR=0, ISR=0, IMR=8'hFF, base=`VEC_RESET`, `intr`=0, `irq`=0, `io_ack`=0, `io_rdata`=0, synchronizer and edge flops cleared.
- **I/O latency.**
  - `io_ack` and `io_rdata` are registered, valid exactly one cycle after `io_access` is sampled high with a matching address.
  - Back-to-back accesses each receive one ack.
  - Read data reflects register state at the sampling edge.
  - A write takes effect on the same edge that registers the ack.
- **Request latency.** An `irq_in` edge reaches IRR 3 cycles later (2 synchronizer flops plus 1 edge flop). `intr` is registered and rises 1 cycle after IRR/IMR/ISR change, so 4 cycles worst case from `irq_in`.
- **Vector timing.** `irq` is valid 1 cycle after the `inta` rising edge. `intr` re-evaluates on the following cycle.
- **Same-cycle events:**
  - New edge on bit n while an `inta` clears IRR[n]: IRR[n] stays set.
  - EOI write and `inta` edge in one cycle: the EOI is applied first, then the ISR set.
  - IMR write and `inta` edge in one cycle: arbitration uses the old IMR.
- **Reset during activity.** Reset during a pending access drops it, with no ack. Reset while `inta` is high is treated as a fresh start: no edge is seen until `inta` falls and rises again.

## Structure
- **Package `pic_pkg`:**
  - `PIC_W0_OFS`, `PIC_W1_OFS`
  - `EOI_NONSPEC`=8'h20, `EOI_SPEC`=3'b011 as the top command bits
  - `IMR_RESET`=8'hFF
  - `SPURIOUS_IDX`=3'd7
- **Sub-module `pic_prio_enc`:** 8-bit lowest-index-first priority encoder with a valid output. It is instanced twice, once for `pend` and once for ISR.

## Test plan
- **Reset values:** after reset, read word 1 → `io_rdata`=16'h08FF with `io_ack` one cycle after `io_access`. Read word 0 → 16'h0000. Access at 16'h0024 → no `io_ack`, `io_rdata`=0.
- **Single request:** write word 1 = 16'h08FE, then pulse `irq_in[0]` → `intr`=1 within 4 cycles. Pulse `inta` → `irq`=8'h08, ISR=8'h01, IRR=0, `intr` falls. Write 8'h20 to word 0 → ISR=0.
- **Nesting:** IMR=0, raise `irq_in[3]` and ack it (`irq`=8'h0B). Raise `irq_in[5]` → `intr` stays 0. Raise `irq_in[1]` → `intr`=1; ack gives `irq`=8'h09 and ISR=8'h0A. Specific EOI 8'h61 → ISR=8'h08.
- **Masking and base:** IMR=8'hFB, base byte write 8'h70 with `io_bytesel`=2'b10, `irq_in[2]` edge → ack gives `irq`=8'h72. Then `irq_in[4]` edge → `intr` stays 0, IRR=8'h10.
- **Spurious acknowledge:** `inta` edge with `pend`=0 → `irq`=base|7, ISR unchanged.
- **Same-cycle collision:** `irq_in[0]` edge detected in the same cycle as the `inta` edge acknowledging bit 0 → IRR[0] remains 1, ISR[0]=1.
